// File: rtl/ccff_chain_loader_if.sv
// Host-side word stream into the configuration chain loader.
// The host drives data/valid; the loader answers with ready.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
) ();

  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/ccff_chain_loader.sv
// Initiator end of a ccff configuration shift chain.
// Takes host words over valid/ready, shifts them MSB-first into the chain
// head while config_enable is high, counts exactly CHAIN_LEN shifts, pulses
// done at the end, and counts the ones that fall out of the chain tail.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 36,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic               prog_clk,
  input  logic               pReset,
  input  logic               start,
  input  logic               abort,
  ccff_chain_loader_if.slave host,
  output logic               ccff_head,
  output logic               config_enable,
  input  logic               ccff_tail,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   tail_ones
);

  localparam int WB_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shiftReg_q;
  logic [WORD_W-1:0] shiftNext;
  logic              head_q;
  logic              cfgEn_q;
  logic              done_q;
  logic [CNT_W-1:0]  tailOnes_q;
  logic [CNT_W-1:0]  bitsLeft_q;
  logic [WB_W-1:0]   wordBits_q;
  logic [WB_W-1:0]   wordTake;

  logic startOk;
  logic accept;
  logic shiftEn;
  logic wordEnd;
  logic lastBit;

  // Handshake and shift qualifiers; abort suppresses everything it overlaps.
  assign startOk   = (state_q == IDLE) && start && !abort;
  assign accept    = (state_q == LOAD) && host.s_valid && !abort;
  assign shiftEn   = (state_q == SHIFT) && cfgEn_q && !abort;
  assign wordEnd   = shiftEn && (wordBits_q == WB_W'(1));
  assign lastBit   = wordEnd && (bitsLeft_q == CNT_W'(1));
  assign shiftNext = shiftReg_q << 1;

  // A short final word only contributes the bits the chain still needs.
  assign wordTake = (bitsLeft_q < CNT_W'(WORD_W)) ? WB_W'(bitsLeft_q)
                                                   : WB_W'(WORD_W);

  // State register.
  always_ff @(posedge prog_clk) begin
    if (pReset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: abort always returns to IDLE, a word end picks LOAD or IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (startOk) state_d = LOAD;
      LOAD: begin
        if (abort)             state_d = IDLE;
        else if (host.s_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (abort)        state_d = IDLE;
        else if (wordEnd) state_d = lastBit ? IDLE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs: ready only while waiting for a word.
  always_comb begin
    host.s_ready = (state_q == LOAD);
    busy         = (state_q != IDLE);
  end

  // Datapath: word capture, serialisation, bit budget and tail ones count.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      shiftReg_q <= '0;
      head_q     <= 1'b0;
      cfgEn_q    <= 1'b0;
      done_q     <= 1'b0;
      tailOnes_q <= '0;
      bitsLeft_q <= '0;
      wordBits_q <= '0;
    end else begin
      done_q <= lastBit;
      if (startOk) begin
        bitsLeft_q <= CNT_W'(CHAIN_LEN);
        tailOnes_q <= '0;
      end
      if (abort && (state_q != IDLE)) begin
        cfgEn_q <= 1'b0;
      end else if (accept) begin
        shiftReg_q <= host.s_data;
        head_q     <= host.s_data[WORD_W-1];
        cfgEn_q    <= 1'b1;
        wordBits_q <= wordTake;
      end else if (shiftEn) begin
        bitsLeft_q <= bitsLeft_q - CNT_W'(1);
        wordBits_q <= wordBits_q - WB_W'(1);
        if (ccff_tail && (tailOnes_q != {CNT_W{1'b1}}))
          tailOnes_q <= tailOnes_q + CNT_W'(1);
        shiftReg_q <= shiftNext;
        head_q     <= shiftNext[WORD_W-1];
        if (wordEnd) cfgEn_q <= 1'b0;
      end
    end
  end

  assign ccff_head     = head_q;
  assign config_enable = cfgEn_q;
  assign done          = done_q;
  assign tail_ones     = tailOnes_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for the ccff chain loader: a 36-bit DUT feeding a model chain, plus
// a one-bit-chain DUT for the minimum length case.
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  logic pReset;

  logic        start0, abort0, head0, cfg0, busy0, done0, tail0;
  logic [15:0] tailOnes0;
  logic        start1, abort1, head1, cfg1, busy1, done1, tail1;
  logic [15:0] tailOnes1;

  ccff_chain_loader_if #(.WORD_W(8)) hostIf0 ();
  ccff_chain_loader_if #(.WORD_W(8)) hostIf1 ();

  ccff_chain_loader #(.CHAIN_LEN(36), .WORD_W(8), .CNT_W(16)) dut0 (
    .prog_clk(clk), .pReset(pReset), .start(start0), .abort(abort0),
    .host(hostIf0), .ccff_head(head0), .config_enable(cfg0),
    .ccff_tail(tail0), .busy(busy0), .done(done0), .tail_ones(tailOnes0)
  );

  ccff_chain_loader #(.CHAIN_LEN(1), .WORD_W(8), .CNT_W(16)) dut1 (
    .prog_clk(clk), .pReset(pReset), .start(start1), .abort(abort1),
    .host(hostIf1), .ccff_head(head1), .config_enable(cfg1),
    .ccff_tail(tail1), .busy(busy1), .done(done1), .tail_ones(tailOnes1)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int failCount = 0;
  int cycleCnt = 0;
  int cfgCount = 0;
  int doneCount = 0;
  int loadCycle = 0;
  int expRemaining = 0;
  int lat;
  logic sbQ[$];
  logic [7:0] words[5];

  logic [35:0] chain = '0;
  logic [35:0] preloadVal = '0;
  logic        preloadReq = 1'b0;

  // Free-running cycle count for latency measurement.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Model of the tile chain: shifts the head bit in whenever enabled.
  always @(posedge clk) begin
    if (preloadReq) chain <= preloadVal;
    else if (cfg0)  chain <= {chain[34:0], head0};
  end
  assign tail0 = chain[35];

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    testsRun++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every enabled shift must present the next queued bit.
  always @(negedge clk) begin
    if (cfg0) begin
      cfgCount++;
      if (sbQ.size() == 0) checkOutput("sbEmpty", 1, 0);
      else                 checkOutput("head", head0, sbQ.pop_front());
    end
    if (done0) doneCount++;
  end

  task automatic startLoad(input bit doPreload, input logic [35:0] pv);
    preloadReq = doPreload;
    preloadVal = pv;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    preloadReq = 1'b0;
    loadCycle = cycleCnt;
    cfgCount = 0;
    doneCount = 0;
    expRemaining = 36;
    sbQ.delete();
  endtask

  // Offer one word (optionally after a gap in LOAD) and queue its bits.
  task automatic applyStimulus(input logic [7:0] w, input int gap);
    int guard;
    int nb;
    hostIf0.s_data  = w;
    hostIf0.s_valid = (gap == 0);
    guard = 0;
    while (!hostIf0.s_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!hostIf0.s_ready) begin
      checkOutput("readyTimeout", 0, 1);
      hostIf0.s_valid = 1'b0;
      return;
    end
    for (int g = 0; g < gap; g++) begin
      checkOutput("gapCfg", cfg0, 0);
      @(negedge clk);
    end
    hostIf0.s_valid = 1'b1;
    nb = (expRemaining < 8) ? expRemaining : 8;
    for (int i = 0; i < nb; i++) sbQ.push_back(w[7-i]);
    expRemaining -= nb;
    @(negedge clk);
  endtask

  task automatic sendWords(input int gap3, input bit pulseStart);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(words[i], (i == 2) ? gap3 : 0);
      if (pulseStart && i == 0) begin
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
      end
    end
    hostIf0.s_valid = 1'b0;
  endtask

  task automatic waitDone(output int latency);
    logic prevBusy;
    latency = -1;
    prevBusy = busy0;
    for (int i = 0; i < 300; i++) begin
      if (done0) begin
        latency = cycleCnt - loadCycle;
        checkOutput("busyBeforeDone", prevBusy, 1);
        checkOutput("busyFall", busy0, 0);
        return;
      end
      prevBusy = busy0;
      @(negedge clk);
    end
    checkOutput("doneTimeout", 0, 1);
  endtask

  task automatic checkLoadEnd(input int expLat, input int expTail);
    waitDone(lat);
    checkOutput("doneLatency", lat, expLat);
    repeat (3) @(negedge clk);
    checkOutput("cfgEdges", cfgCount, 36);
    checkOutput("doneOnce", doneCount, 1);
    checkOutput("tailOnes", tailOnes0, expTail);
    checkOutput("chainImage", chain, 36'hA53CFF009);
    checkOutput("sbDrained", sbQ.size(), 0);
    checkOutput("idleBusy", busy0, 0);
  endtask

  initial begin
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
    words[3] = 8'h00; words[4] = 8'h9F;
    pReset = 1'b1;
    start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0; tail1 = 1'b1;
    hostIf0.s_data = '0; hostIf0.s_valid = 1'b0;
    hostIf1.s_data = '0; hostIf1.s_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstReady", hostIf0.s_ready, 0);
    checkOutput("rstHead", head0, 0);
    checkOutput("rstCfg", cfg0, 0);
    checkOutput("rstBusy", busy0, 0);
    checkOutput("rstDone", done0, 0);
    checkOutput("rstTail", tailOnes0, 0);
    pReset = 1'b0;
    @(negedge clk);

    // Back-to-back words into a chain preloaded with 0xF00F.
    startLoad(1'b1, 36'h0_0000_F00F);
    sendWords(0, 1'b0);
    checkLoadEnd(41, 8);

    // Five idle LOAD cycles before the third word.
    startLoad(1'b0, '0);
    sendWords(5, 1'b0);
    checkLoadEnd(46, 18);

    // Abort partway through the second word; 7 ones have left the tail.
    startLoad(1'b0, '0);
    applyStimulus(words[0], 0);
    applyStimulus(words[1], 0);
    repeat (5) @(negedge clk);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    hostIf0.s_valid = 1'b0;
    checkOutput("abortCfg", cfg0, 0);
    checkOutput("abortBusy", busy0, 0);
    checkOutput("abortDone", done0, 0);
    checkOutput("abortTail", tailOnes0, 7);
    sbQ.delete();
    repeat (2) @(negedge clk);
    checkOutput("abortNoDone", doneCount, 0);
    checkOutput("abortTailFrozen", tailOnes0, 7);
    startLoad(1'b0, '0);
    checkOutput("restartTail", tailOnes0, 0);
    sendWords(0, 1'b0);
    checkLoadEnd(41, 18);

    // Reset in the middle of a shift, then a load with a stray start.
    startLoad(1'b0, '0);
    applyStimulus(words[0], 0);
    repeat (2) @(negedge clk);
    pReset = 1'b1;
    @(negedge clk);
    pReset = 1'b0;
    hostIf0.s_valid = 1'b0;
    checkOutput("midRstHead", head0, 0);
    checkOutput("midRstCfg", cfg0, 0);
    checkOutput("midRstBusy", busy0, 0);
    checkOutput("midRstDone", done0, 0);
    checkOutput("midRstReady", hostIf0.s_ready, 0);
    checkOutput("midRstTail", tailOnes0, 0);
    sbQ.delete();
    @(negedge clk);
    startLoad(1'b0, '0);
    sendWords(0, 1'b1);
    checkLoadEnd(41, 18);

    // One-bit chain: a single shift of the word's MSB, then done.
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checkOutput("len1Ready", hostIf1.s_ready, 1);
    hostIf1.s_data = 8'h80;
    hostIf1.s_valid = 1'b1;
    @(negedge clk);
    hostIf1.s_valid = 1'b0;
    checkOutput("len1Cfg", cfg1, 1);
    checkOutput("len1Head", head1, 1);
    @(negedge clk);
    checkOutput("len1CfgOff", cfg1, 0);
    checkOutput("len1Done", done1, 1);
    checkOutput("len1Busy", busy1, 0);
    checkOutput("len1Tail", tailOnes1, 1);
    @(negedge clk);
    checkOutput("len1DonePulse", done1, 0);
    start1 = 1'b1;
    abort1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    abort1 = 1'b0;
    checkOutput("startAbortBusy", busy1, 0);
    checkOutput("startAbortReady", hostIf1.s_ready, 0);
    @(negedge clk);
    checkOutput("startAbortCfg", cfg1, 0);
    checkOutput("startAbortIdle", busy1, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
Name:
ccff_chain_loader

Overview:
- Configuration-chain driver: the initiator end of the ccff shift chain used by the routing tiles.
- Accepts bitstream words from a host over a valid/ready stream and serializes them MSB-first onto ccff_head.
- Gates chain shifting with config_enable.
- Counts exactly CHAIN_LEN shift cycles, then pulses done.
- Samples ccff_tail on every shift cycle and counts the ones that emerge, so software can read back or verify the previous chain contents.
- Sits at the fabric edge and drives the head of a tile column's chain, with prog_clk and pReset shared with the tiles.

Parameters:
CHAIN_LEN, 36, total configuration bits in the chain (number of shift cycles per load).
WORD_W, 8, host word width in bits.
CNT_W, 16, width of the bit and ones counters; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
prog_clk  in  1  programming clock; all state on the rising edge.
pReset  in  1  synchronous, active-high reset.
start  in  1  single-cycle request to begin a load; honoured only in IDLE.
abort  in  1  synchronous cancel of an active load.
s_data  in  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
s_valid  in  1  s_data valid.
s_ready  out  1  loader can accept a word this cycle.
ccff_head  out  1  serial config bit to the chain head, registered.
config_enable  out  1  chain shift enable, registered; chain shifts on each edge where it is 1.
ccff_tail  in  1  serial bit returning from the chain tail.
busy  out  1  load in progress.
done  out  1  one-cycle pulse after the final bit.
tail_ones  out  CNT_W  count of 1s sampled on ccff_tail during the current or last load.

Behaviour:
- Reset (pReset=1 at an edge): state IDLE.
  - s_ready, ccff_head, config_enable, busy, done all 0.
  - tail_ones=0; bits_left=0.
  - pReset mid-load behaves like abort, and additionally clears tail_ones.
- States: IDLE, LOAD, SHIFT.
- IDLE:
  - start=1 -> LOAD next cycle, busy=1, bits_left=CHAIN_LEN, tail_ones=0.
  - start is ignored outside IDLE.
- LOAD:
  - s_ready=1 and config_enable=0; the chain holds.
  - On an edge with s_valid=1, the word is accepted:
    - sr <= s_data.
    - ccff_head <= s_data[WORD_W-1].
    - config_enable <= 1.
    - word_bits <= min(WORD_W, bits_left).
    - State -> SHIFT.
  - No accept -> stay in LOAD.
- SHIFT:
  - s_ready=0.
  - Each edge with config_enable=1:
    - bits_left decrements.
    - tail_ones increments if ccff_tail=1, saturating at 2^CNT_W-1.
    - word_bits decrements.
    - The next sr bit is presented on ccff_head.
  - When word_bits reaches 0 after the final bit of the word:
    - config_enable <= 0.
    - If bits_left=0: busy <= 0, done <= 1 for one cycle, state -> IDLE.
    - Otherwise: state -> LOAD.
- Last word when CHAIN_LEN is not a multiple of WORD_W: only the top (CHAIN_LEN mod WORD_W) bits are shifted; low bits are discarded.
- Throughput: each full word costs 1 LOAD cycle + WORD_W SHIFT cycles when s_valid is held high.
- Gaps between words never shift the chain, because config_enable=0 while waiting.
- config_enable is 1 for exactly CHAIN_LEN edges per completed load.
- ccff_head is don't-care while config_enable=0; it holds its last value.
- abort=1 in LOAD or SHIFT:
  - Next cycle: IDLE, config_enable=0, busy=0, no done pulse.
  - tail_ones freezes.
  - Any word accepted in the same cycle as abort is dropped.
  - abort in IDLE has no effect.
- start and abort asserted together in IDLE: abort wins, stay IDLE.
- CHAIN_LEN=0 is illegal. CHAIN_LEN=1 must work: one word accepted, one shift, done.

Test Plan:
1. Reset, CHAIN_LEN=36, WORD_W=8, s_valid held 1 with words 0xA5,0x3C,0xFF,0x00,0x9F:
   - config_enable high for exactly 36 edges.
   - ccff_head sequence is 10100101 00111100 11111111 00000000 1001.
   - done pulses once, 5*1+4*8+4=41 cycles after the first LOAD cycle.
   - busy falls together with the done pulse.
2. Same load with ccff_tail driven from a 36-bit model chain preloaded with 0x0_0000_F00F:
   - tail_ones=8 after done.
   - The model chain then holds the loaded bitstream.
3. s_valid deasserted for 5 cycles between words 2 and 3:
   - config_enable stays 0 throughout the gap.
   - The chain contents are identical to scenario 1.
   - done arrives 5 cycles later than in scenario 1.
4. abort after 13 shifted bits:
   - Next cycle: config_enable=0, busy=0, no done.
   - A new start restarts with bits_left=36 and tail_ones=0.
5. pReset asserted mid-SHIFT: all outputs 0 the next cycle and tail_ones=0; start pulsed while busy is ignored (no restart, same done timing).
6. CHAIN_LEN=1, word 0x80: one config_enable edge with ccff_head=1, then done; a start and abort together in IDLE produce no activity.
